// File: rtl/int_issue_queue8_pkg.sv
// Shared sizes and the per-entry record for the 8-entry integer issue queue.
package int_iq_pkg;

    localparam int IQDEEP = 8;
    localparam int SLOTW  = 3;
    localparam int TAGW   = 6;
    localparam int PAYW   = 32;

    typedef struct packed {
        logic            valid;
        logic [PAYW-1:0] payload;
        logic [TAGW-1:0] dst;
        logic [TAGW-1:0] src1_tag;
        logic            src1_rdy;
        logic [TAGW-1:0] src2_tag;
        logic            src2_rdy;
    } iq_entry_t;

    function automatic logic tag_hit(
        input logic            wv,
        input logic [TAGW-1:0] wt,
        input logic [TAGW-1:0] t
    );
        return wv && (wt == t);
    endfunction

endpackage

// File: rtl/int_issue_queue8_if.sv
// Dispatch, free-list, wakeup, issue and flush signals of the issue queue.
interface int_issue_queue8_if #(
    parameter int SLOTW = int_iq_pkg::SLOTW,
    parameter int TAGW  = int_iq_pkg::TAGW,
    parameter int PAYW  = int_iq_pkg::PAYW
);
    logic            DispValid;
    logic [PAYW-1:0] DispPayload;
    logic [TAGW-1:0] DispDst;
    logic [TAGW-1:0] DispSrc1Tag;
    logic            DispSrc1Rdy;
    logic [TAGW-1:0] DispSrc2Tag;
    logic            DispSrc2Rdy;
    logic            DispReady;

    logic [SLOTW-1:0] FlPreOut;
    logic             FlEmpty;
    logic             FlRable;
    logic             FlWable;
    logic [SLOTW-1:0] FlDin;
    logic             FlClean;

    logic            WakeValid;
    logic [TAGW-1:0] WakeTag;

    logic             IssueValid;
    logic [PAYW-1:0]  IssuePayload;
    logic [TAGW-1:0]  IssueDst;
    logic [SLOTW-1:0] IssueSlot;
    logic             IssueReady;

    logic IqClean;

    modport master (
        output DispValid, DispPayload, DispDst,
        output DispSrc1Tag, DispSrc1Rdy, DispSrc2Tag, DispSrc2Rdy,
        input  DispReady,
        output FlPreOut, FlEmpty,
        input  FlRable, FlWable, FlDin, FlClean,
        output WakeValid, WakeTag,
        input  IssueValid, IssuePayload, IssueDst, IssueSlot,
        output IssueReady,
        output IqClean
    );

    modport slave (
        input  DispValid, DispPayload, DispDst,
        input  DispSrc1Tag, DispSrc1Rdy, DispSrc2Tag, DispSrc2Rdy,
        output DispReady,
        input  FlPreOut, FlEmpty,
        output FlRable, FlWable, FlDin, FlClean,
        input  WakeValid, WakeTag,
        output IssueValid, IssuePayload, IssueDst, IssueSlot,
        input  IssueReady,
        input  IqClean
    );

endinterface

// File: rtl/int_issue_queue8_select.sv
// Fixed-priority picker: lowest-index eligible entry wins.
module int_iq_select #(
    parameter int IQDEEP = int_iq_pkg::IQDEEP,
    parameter int SLOTW  = int_iq_pkg::SLOTW
) (
    input  logic [IQDEEP-1:0] eligible,
    output logic [IQDEEP-1:0] grant,
    output logic [SLOTW-1:0]  idx,
    output logic              found
);

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = IQDEEP - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = SLOTW'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_issue_queue8.sv
// Integer issue queue: slots come from an external free list, wakeups
// mark sources ready, and the lowest ready slot issues.
module int_issue_queue8 #(
    parameter int IQDEEP = int_iq_pkg::IQDEEP,
    parameter int SLOTW  = int_iq_pkg::SLOTW,
    parameter int TAGW   = int_iq_pkg::TAGW,
    parameter int PAYW   = int_iq_pkg::PAYW
) (
    input logic               Clk,
    input logic               Rest,
    int_issue_queue8_if.slave io
);
    import int_iq_pkg::*;

    iq_entry_t         ent [IQDEEP];
    iq_entry_t         disp_ent;
    logic [IQDEEP-1:0] eligible;
    logic [IQDEEP-1:0] grant;
    logic [SLOTW-1:0]  sel_idx;
    logic              sel_found;
    logic              disp_ready;
    logic              disp_fire;
    logic              issue_valid;
    logic              issue_fire;
    logic [SLOTW-1:0]  issue_slot;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < IQDEEP; i++) begin
            eligible[i] = ent[i].valid
                       && ent[i].src1_rdy
                       && ent[i].src2_rdy;
        end
    end

    int_iq_select #(
        .IQDEEP(IQDEEP),
        .SLOTW (SLOTW)
    ) u_select (
        .eligible(eligible),
        .grant   (grant),
        .idx     (sel_idx),
        .found   (sel_found)
    );

    assign disp_ready  = Rest && !io.FlEmpty && !io.IqClean;
    assign disp_fire   = io.DispValid && disp_ready;
    assign issue_valid = sel_found && Rest && !io.IqClean;
    assign issue_fire  = issue_valid && io.IssueReady;
    assign issue_slot  = issue_valid ? sel_idx : '0;

    // A wakeup in the dispatch cycle is folded into the captured ready bits.
    always_comb begin
        disp_ent          = '0;
        disp_ent.valid    = 1'b1;
        disp_ent.payload  = io.DispPayload;
        disp_ent.dst      = io.DispDst;
        disp_ent.src1_tag = io.DispSrc1Tag;
        disp_ent.src2_tag = io.DispSrc2Tag;
        disp_ent.src1_rdy = io.DispSrc1Rdy
                         || tag_hit(io.WakeValid, io.WakeTag,
                                    io.DispSrc1Tag);
        disp_ent.src2_rdy = io.DispSrc2Rdy
                         || tag_hit(io.WakeValid, io.WakeTag,
                                    io.DispSrc2Tag);
    end

    assign io.DispReady    = disp_ready;
    assign io.FlRable      = disp_fire;
    assign io.FlWable      = issue_fire;
    assign io.FlDin        = issue_slot;
    assign io.FlClean      = Rest && io.IqClean;
    assign io.IssueValid   = issue_valid;
    assign io.IssueSlot    = issue_slot;
    assign io.IssuePayload = issue_valid ? ent[sel_idx].payload : '0;
    assign io.IssueDst     = issue_valid ? ent[sel_idx].dst : '0;

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            for (int i = 0; i < IQDEEP; i++) begin
                ent[i].valid    <= 1'b0;
                ent[i].src1_rdy <= 1'b0;
                ent[i].src2_rdy <= 1'b0;
            end
        end else if (io.IqClean) begin
            for (int i = 0; i < IQDEEP; i++) begin
                ent[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < IQDEEP; i++) begin
                if (ent[i].valid
                    && tag_hit(io.WakeValid, io.WakeTag,
                               ent[i].src1_tag)) begin
                    ent[i].src1_rdy <= 1'b1;
                end
                if (ent[i].valid
                    && tag_hit(io.WakeValid, io.WakeTag,
                               ent[i].src2_tag)) begin
                    ent[i].src2_rdy <= 1'b1;
                end
                if (issue_fire && grant[i]) begin
                    ent[i].valid <= 1'b0;
                end
                if (disp_fire && io.FlPreOut == SLOTW'(i)) begin
                    ent[i] <= disp_ent;
                end
            end
        end
    end

endmodule

// File: tb/tb_int_issue_queue8.sv
// Scoreboard bench for int_issue_queue8: directed scenarios then random
// traffic, checked against a slot-array reference model.
module tb_int_issue_queue8;

    localparam int N = 8;

    logic Clk = 1'b0;
    logic Rest;

    always #5 Clk = ~Clk;

    int_issue_queue8_if #(.SLOTW(3), .TAGW(6), .PAYW(32)) io ();

    int_issue_queue8 dut (
        .Clk (Clk),
        .Rest(Rest),
        .io  (io)
    );

    typedef struct {
        bit          v;
        logic [31:0] pay;
        logic [5:0]  dst;
        logic [5:0]  t1;
        logic [5:0]  t2;
        bit          r1;
        bit          r2;
    } m_ent_t;

    typedef struct packed {
        logic        dr;
        logic        rab;
        logic        wab;
        logic        cln;
        logic [2:0]  din;
        logic        iv;
        logic [31:0] ip;
        logic [5:0]  id;
        logic [2:0]  slot;
    } exp_t;

    m_ent_t m [N];
    int     free_q[$];
    exp_t   exp_q[$];
    exp_t   mon_e;
    int     n_chk  = 0;
    int     n_fail = 0;

    bit p_fd;
    bit p_fi;
    int p_sel;

    logic        s_dv, s_r1, s_r2, s_wv, s_ir, s_fe, s_cln;
    logic [31:0] s_pay;
    logic [5:0]  s_dst, s_t1, s_t2, s_wt;

    function automatic void chk(input string name,
                                input logic [63:0] act,
                                input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t",
                     name, act, req, $time);
        end
    endfunction

    task automatic reinit_free();
        free_q.delete();
        for (int i = 0; i < N; i++) free_q.push_back(i);
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) m[i].v = 1'b0;
        reinit_free();
    endtask

    task automatic idle();
        s_dv = 0; s_pay = '0; s_dst = '0;
        s_t1 = '0; s_r1 = 0; s_t2 = '0; s_r2 = 0;
        s_wv = 0; s_wt = '0; s_ir = 0; s_fe = 0; s_cln = 0;
    endtask

    task automatic disp(input logic [31:0] pay, input logic [5:0] dst,
                        input logic [5:0] t1, input logic r1,
                        input logic [5:0] t2, input logic r2);
        s_dv = 1; s_pay = pay; s_dst = dst;
        s_t1 = t1; s_r1 = r1; s_t2 = t2; s_r2 = r2;
    endtask

    task automatic apply();
        io.DispValid   = s_dv;
        io.DispPayload = s_pay;
        io.DispDst     = s_dst;
        io.DispSrc1Tag = s_t1;
        io.DispSrc1Rdy = s_r1;
        io.DispSrc2Tag = s_t2;
        io.DispSrc2Rdy = s_r2;
        io.WakeValid   = s_wv;
        io.WakeTag     = s_wt;
        io.IssueReady  = s_ir;
        io.IqClean     = s_cln;
        io.FlEmpty     = s_fe || free_q.size() == 0;
        io.FlPreOut    = free_q.size() != 0 ? 3'(free_q[0]) : 3'd0;
    endtask

    // Expected outputs for the inputs just applied.
    task automatic predict();
        exp_t e;
        int   sel;
        e   = '0;
        sel = -1;
        for (int i = 0; i < N; i++) begin
            if (m[i].v && m[i].r1 && m[i].r2) begin
                sel = i;
                break;
            end
        end
        e.dr  = Rest && !io.FlEmpty && !io.IqClean;
        e.rab = io.DispValid && e.dr;
        e.iv  = (sel >= 0) && Rest && !io.IqClean;
        if (e.iv) begin
            e.ip   = m[sel].pay;
            e.id   = m[sel].dst;
            e.slot = 3'(sel);
        end
        e.wab = e.iv && io.IssueReady;
        e.din = e.slot;
        e.cln = Rest && io.IqClean;
        exp_q.push_back(e);
        p_fd  = e.rab;
        p_fi  = e.wab;
        p_sel = sel;
    endtask

    task automatic update();
        int s;
        if (!Rest) return;
        if (io.IqClean) begin
            model_clear();
            return;
        end
        if (io.WakeValid) begin
            for (int i = 0; i < N; i++) begin
                if (m[i].v && m[i].t1 == io.WakeTag) m[i].r1 = 1;
                if (m[i].v && m[i].t2 == io.WakeTag) m[i].r2 = 1;
            end
        end
        if (p_fi) m[p_sel].v = 0;
        if (p_fd) begin
            s        = free_q.pop_front();
            m[s].v   = 1;
            m[s].pay = io.DispPayload;
            m[s].dst = io.DispDst;
            m[s].t1  = io.DispSrc1Tag;
            m[s].t2  = io.DispSrc2Tag;
            m[s].r1  = io.DispSrc1Rdy
                    || (io.WakeValid && io.WakeTag == io.DispSrc1Tag);
            m[s].r2  = io.DispSrc2Rdy
                    || (io.WakeValid && io.WakeTag == io.DispSrc2Tag);
        end
        if (p_fi) free_q.push_back(p_sel);
    endtask

    task automatic tick();
        @(negedge Clk);
        apply();
        #1;
        predict();
        @(posedge Clk);
        update();
    endtask

    // Called right after a tick; asserts reset between clock edges.
    task automatic reset_async();
        #3 Rest = 1'b0;
        #1;
        chk("rst_issue_valid", 64'(io.IssueValid), 64'd0);
        chk("rst_disp_ready", 64'(io.DispReady), 64'd0);
        chk("rst_fl_rable", 64'(io.FlRable), 64'd0);
        chk("rst_fl_wable", 64'(io.FlWable), 64'd0);
        chk("rst_fl_clean", 64'(io.FlClean), 64'd0);
        model_clear();
        tick();
        tick();
        #3 Rest = 1'b1;
    endtask

    always @(negedge Clk) begin
        #2;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("ctl",
                64'({io.DispReady, io.FlRable, io.FlWable,
                     io.FlClean, io.FlDin}),
                64'({mon_e.dr, mon_e.rab, mon_e.wab,
                     mon_e.cln, mon_e.din}));
            chk("issue",
                64'({io.IssueValid, io.IssuePayload,
                     io.IssueDst, io.IssueSlot}),
                64'({mon_e.iv, mon_e.ip, mon_e.id, mon_e.slot}));
        end
    end

    initial begin
        model_clear();
        idle();
        apply();
        Rest = 1'b1;
        #1 Rest = 1'b0;
        #1;
        chk("init_issue_valid", 64'(io.IssueValid), 64'd0);
        chk("init_disp_ready", 64'(io.DispReady), 64'd0);
        tick();
        tick();
        #3 Rest = 1'b1;

        // Dispatch into slot 5, then issue it.
        free_q = '{5, 0, 1, 2, 3, 4, 6, 7};
        idle(); disp(32'h1111_0005, 6'd7, 6'd1, 1, 6'd2, 1);
        tick();
        idle(); s_ir = 1;
        tick();
        idle();
        tick();

        // Src1 tag 12 woken two cycles after dispatch.
        idle(); s_ir = 1; disp(32'h2222_000c, 6'd8, 6'd12, 0, 6'd3, 1);
        tick();
        idle(); s_ir = 1;
        tick();
        s_wv = 1; s_wt = 6'd12;
        tick();
        idle(); s_ir = 1;
        tick();
        tick();

        // Src2 tag 9 woken in the dispatch cycle.
        idle(); disp(32'h3333_0009, 6'd9, 6'd4, 1, 6'd9, 0);
        s_wv = 1; s_wt = 6'd9;
        tick();
        idle(); s_ir = 1;
        tick();
        tick();

        // Slots 2 and 6 eligible, consumer stalled three cycles.
        idle(); s_cln = 1;
        tick();
        free_q = '{2, 6, 0, 1, 3, 4, 5, 7};
        idle(); disp(32'h4444_0002, 6'd10, 6'd0, 1, 6'd0, 1);
        tick();
        idle(); disp(32'h4444_0006, 6'd11, 6'd0, 1, 6'd0, 1);
        tick();
        idle();
        repeat (3) tick();
        s_ir = 1;
        repeat (3) tick();

        // Empty free list, then dispatch and issue together.
        idle(); s_fe = 1; disp(32'h5555_0000, 6'd12, 6'd0, 1, 6'd0, 1);
        tick();
        idle(); disp(32'h5555_0001, 6'd13, 6'd0, 1, 6'd0, 1);
        tick();
        disp(32'h5555_0002, 6'd14, 6'd0, 1, 6'd0, 1); s_ir = 1;
        tick();
        idle(); s_ir = 1;
        tick();
        tick();

        // Four entries, then a flush that competes with dispatch/issue.
        for (int k = 0; k < 4; k++) begin
            idle(); disp(32'h6666_0000 + k, 6'(k), 6'd0, 1, 6'd0, 1);
            tick();
        end
        disp(32'h6666_00ff, 6'd20, 6'd0, 1, 6'd0, 1);
        s_ir = 1; s_cln = 1; s_wv = 1; s_wt = 6'd0;
        tick();
        idle(); s_ir = 1;
        tick();
        tick();

        // Reset in the middle of a dispatch burst.
        for (int k = 0; k < 3; k++) begin
            idle(); disp(32'h7777_0000 + k, 6'(k), 6'd0, 1, 6'd0, 1);
            tick();
        end
        #2 chk("pre_rst_issue_valid", 64'(io.IssueValid), 64'd1);
        reset_async();

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            idle();
            if ($urandom_range(0, 9) < 7) begin
                disp($urandom, 6'($urandom_range(0, 63)),
                     6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                     6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end
            s_wv  = 1'($urandom_range(0, 1));
            s_wt  = 6'($urandom_range(0, 15));
            s_ir  = $urandom_range(0, 9) < 6;
            s_fe  = $urandom_range(0, 9) == 0;
            s_cln = $urandom_range(0, 49) == 0;
            tick();
            if (c == 300) reset_async();
        end

        idle(); s_ir = 1;
        tick();
        tick();
        #3;
        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
